hls_deadlock_monitor_param: RTL and testbench
=============================================

Name: hls_deadlock_monitor_param

Overview:
- Parametrised, persistence-filtered deadlock monitor for an HLS dataflow region.
- Instantiated once per dataflow instance, beside the region's process instances.
- Flags a deadlock when every process is stopped (idle, channel-blocked or AXIS-blocked) and at least one is AXIS-blocked.
- The condition must hold for THRESHOLD consecutive cycles. The monitor then latches a sticky flag and captures which processes were AXIS-blocked.

Parameters:
- NUM_PROC, 12, number of dataflow processes monitored (>=1).
- NUM_AXIS, 2, number of AXIS block inputs (>=1).
- AXIS_MAP, {NUM_PROC*NUM_AXIS{1'b0}}, ownership mask. Bit [p*NUM_AXIS+a]=1 means AXIS input a belongs to process p.
- CNT_W, 8, width of the persistence counter.
- THRESHOLD, 16, number of consecutive candidate cycles needed to lock. Legal range 1..2^CNT_W-1.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- axis_block_sigs  in  NUM_AXIS  per-AXIS-port blocked indication.
- inst_idle_sigs  in  NUM_PROC  per-process idle.
- inst_block_sigs  in  NUM_PROC  per-process channel (FIFO/PIPO) blocked.
- clear  in  1  one-cycle pulse; releases the lock and restarts counting.
- block  out  1  registered raw candidate, one cycle after the inputs.
- deadlock  out  1  high while the FSM is in LOCKED.
- deadlock_proc_vec  out  NUM_PROC  snapshot of per-process AXIS-block at lock time.
- stall_count  out  CNT_W  current persistence count.

Behaviour:
- Combinational terms:
  - axblk[p] = |(axis_block_sigs & AXIS_MAP[p*NUM_AXIS +: NUM_AXIS]).
  - stop[p] = inst_idle_sigs[p] | inst_block_sigs[p] | axblk[p].
  - cand = (|axblk) & (&stop).
- block <= cand every cycle. It is not affected by the FSM or by clear.
- FSM states: IDLE, ARMED, LOCKED. stall_count is the cnt register.
- IDLE (cnt=0):
  - cand & !clear: cnt<=1. Go LOCKED if THRESHOLD==1, otherwise ARMED.
  - Else stay in IDLE.
- ARMED:
  - clear: go IDLE, cnt<=0.
  - !cand: go IDLE, cnt<=0. The run must be consecutive.
  - cand: cnt<=cnt+1. If cnt+1==THRESHOLD, go LOCKED and load deadlock_proc_vec<=axblk in the same edge.
- LOCKED:
  - deadlock=1. cnt holds at THRESHOLD and does not wrap.
  - deadlock_proc_vec holds its value.
  - clear: go IDLE, cnt<=0, deadlock_proc_vec<=0.
  - Otherwise stay, regardless of cand (sticky).
- Latency: deadlock rises on the edge that completes the THRESHOLD-th consecutive cand cycle, i.e. THRESHOLD cycles after cand first goes high.
- clear always wins over cand in the same cycle. Counting restarts on the following cycle if cand persists.
- Reset values: state=IDLE, cnt=0, block=0, deadlock=0, deadlock_proc_vec=0.
- Reset asserted mid-ARMED or mid-LOCKED returns to the reset values on the next edge.
- AXIS inputs with no owner in AXIS_MAP are ignored.
- A process with no owned AXIS inputs has axblk=0.
- With AXIS_MAP all zero, cand is constant 0 and the monitor never locks.

Optional Feature:
- Macro: HLS_DEADLOCK_MON_AUTO_RELEASE_EN.
- Defined: in LOCKED, !cand returns the FSM to IDLE on the next edge. cnt<=0 and deadlock_proc_vec<=0, so deadlock tracks a persisting deadlock. clear still forces IDLE.
- Undefined: LOCKED is sticky until clear or reset, as specified above.

Test Plan:
- Defaults, AXIS_MAP maps axis0->proc1 and axis1->proc2. Drive inst_idle_sigs=0xFFD, axis_block_sigs=2'b01 -> block=1 one cycle later; deadlock rises exactly 16 cycles after cand start; deadlock_proc_vec=0x002; stall_count=16.
- Same stimulus with cand dropped for one cycle at count 10 -> stall_count returns to 0 and deadlock stays 0. Re-assert -> deadlock rises 16 cycles after re-assert.
- Locked, then cand deasserted -> deadlock stays 1 (macro undefined). Pulse clear -> deadlock=0 and deadlock_proc_vec=0 next cycle.
- clear coincident with the 16th cand cycle -> no lock; cnt=0; counting resumes and locks 16 cycles later.
- THRESHOLD=1, NUM_PROC=3, NUM_AXIS=1, inputs all idle, axis blocked by proc0 -> deadlock=1 one cycle after cand. Reset mid-LOCKED -> all outputs 0 next cycle.
- Macro defined: in LOCKED, set inst_idle_sigs=0 -> deadlock=0 next cycle without clear.

Source files
------------

// File: rtl/hls_deadlock_monitor_param.sv
// Persistence-filtered deadlock monitor for one HLS dataflow region.
// Optional macro HLS_DEADLOCK_MON_AUTO_RELEASE_EN drops the lock when the condition clears.
module hls_deadlock_monitor_param #(
  parameter int NUM_PROC = 12,
  parameter int NUM_AXIS = 2,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP = '0,
  parameter int CNT_W = 8,
  parameter int THRESHOLD = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                deadlock,
  output logic [NUM_PROC-1:0] deadlock_proc_vec,
  output logic [CNT_W-1:0]    stall_count
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
  logic [NUM_PROC-1:0] vec, vec_n;
  logic [NUM_PROC-1:0] axblk;
  logic [NUM_PROC-1:0] stop;
  logic                cand;

  // AXIS inputs with no owner never reach any process
  always_comb begin
    axblk = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      axblk[p] = |(axis_block_sigs
                   & AXIS_MAP[p*NUM_AXIS +: NUM_AXIS]);
    end
  end

  assign stop    = inst_idle_sigs | inst_block_sigs | axblk;
  assign cand    = (|axblk) & (&stop);
  assign cnt_inc = cnt + ONE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vec_n   = vec;
    unique case (state)
      IDLE: begin
        if (cand && !clear) begin
          cnt_n = ONE;
          if (THRESHOLD == 1) begin
            state_n = LOCKED;
            vec_n   = axblk;
          end else begin
            state_n = ARMED;
          end
        end
      end
      ARMED: begin
        if (clear || !cand) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == THR) begin
            state_n = LOCKED;
            vec_n   = axblk;
          end
        end
      end
      LOCKED: begin
`ifdef HLS_DEADLOCK_MON_AUTO_RELEASE_EN
        if (clear || !cand) begin
`else
        if (clear) begin
`endif
          state_n = IDLE;
          cnt_n   = '0;
          vec_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        vec_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
      block <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      vec   <= vec_n;
      block <= cand;
    end
  end

  assign deadlock          = (state == LOCKED);
  assign deadlock_proc_vec = vec;
  assign stall_count       = cnt;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Scoreboard bench for hls_deadlock_monitor_param.
// Two instances: default threshold and a THRESHOLD=1 variant.
module tb_hls_deadlock_monitor_param;

  localparam logic [23:0] MAP0 = 24'h000024;
  localparam logic [2:0]  MAP1 = 3'b001;

  typedef struct packed {
    logic        blk;
    logic        dl;
    logic [11:0] vec;
    logic [7:0]  cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ax = '0;
  logic [11:0] idle = '0;
  logic [11:0] blk = '0;
  logic        clr = 1'b0;
  logic        o_blk, o_dl;
  logic [11:0] o_vec;
  logic [7:0]  o_cnt;

  logic [0:0]  ax1 = '0;
  logic [2:0]  idle1 = '0;
  logic [2:0]  blk1 = '0;
  logic        clr1 = 1'b0;
  logic        p_blk, p_dl;
  logic [2:0]  p_vec;
  logic [7:0]  p_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_run [2];
  bit          m_lock[2];
  logic [11:0] m_vec [2];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clock = ~clock;

  hls_deadlock_monitor_param #(
    .NUM_PROC(12), .NUM_AXIS(2), .AXIS_MAP(MAP0),
    .CNT_W(8), .THRESHOLD(16)
  ) dut (
    .clock(clock), .reset(rst),
    .axis_block_sigs(ax), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clr),
    .block(o_blk), .deadlock(o_dl),
    .deadlock_proc_vec(o_vec), .stall_count(o_cnt)
  );

  hls_deadlock_monitor_param #(
    .NUM_PROC(3), .NUM_AXIS(1), .AXIS_MAP(MAP1),
    .CNT_W(8), .THRESHOLD(1)
  ) dut1 (
    .clock(clock), .reset(rst),
    .axis_block_sigs(ax1), .inst_idle_sigs(idle1),
    .inst_block_sigs(blk1), .clear(clr1),
    .block(p_blk), .deadlock(p_dl),
    .deadlock_proc_vec(p_vec), .stall_count(p_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // run-length model: lock once the run reaches thr
  task automatic model(input int k, input int thr,
                       input bit r, input bit c,
                       input bit cand,
                       input logic [11:0] axb,
                       output exp_t e);
    e.blk = r ? 1'b0 : cand;
    if (r || c) begin
      m_run[k] = 0; m_lock[k] = 0; m_vec[k] = '0;
    end else if (m_lock[k]) begin
`ifdef HLS_DEADLOCK_MON_AUTO_RELEASE_EN
      if (!cand) begin
        m_run[k] = 0; m_lock[k] = 0; m_vec[k] = '0;
      end
`endif
    end else if (cand) begin
      m_run[k]++;
      if (m_run[k] == thr) begin
        m_lock[k] = 1; m_vec[k] = axb;
      end
    end else begin
      m_run[k] = 0;
    end
    e.dl  = m_lock[k];
    e.vec = m_vec[k];
    e.cnt = 8'(m_run[k]);
  endtask

  task automatic tick();
    exp_t e0, e1;
    logic [11:0] a0, a1;
    bit c0, c1;
    a0 = '0; a0[1] = ax[0]; a0[2] = ax[1];
    c0 = (|a0) && (&(idle | blk | a0));
    a1 = '0; a1[0] = ax1[0];
    c1 = ax1[0] && (&(idle1 | blk1 | a1[2:0]));
    model(0, 16, rst, clr, c0, a0, e0);
    q0.push_back(e0);
    model(1, 1, rst, clr1, c1, a1, e1);
    q1.push_back(e1);
    @(posedge clock); #1;
    e0 = q0.pop_front();
    chk("blk", o_blk, e0.blk);
    chk("dl", o_dl, e0.dl);
    chk("vec", o_vec, e0.vec);
    chk("cnt", o_cnt, e0.cnt);
    e1 = q1.pop_front();
    chk("blk1", p_blk, e1.blk);
    chk("dl1", p_dl, e1.dl);
    chk("vec1", p_vec, e1.vec[2:0]);
    chk("cnt1", p_cnt, e1.cnt);
    clr = 0; clr1 = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_lock[k] = 0; m_vec[k] = '0;
    end
    rst = 1; ticks(2);
    chk("rst_dl", o_dl, 0);
    chk("rst_cnt", o_cnt, 0);
    rst = 0; tick();

    // basic lock
    idle = 12'hFFD; ax = 2'b01;
    tick();
    chk("blk_lat", o_blk, 1);
    ticks(14);
    chk("pre_lock", o_dl, 0);
    tick();
    chk("lock16", o_dl, 1);
    chk("vec16", o_vec, 12'h002);
    chk("cnt16", o_cnt, 16);
    ax = 2'b00; ticks(3);
`ifndef HLS_DEADLOCK_MON_AUTO_RELEASE_EN
    chk("sticky", o_dl, 1);
    chk("sticky_cnt", o_cnt, 16);
`endif
    clr = 1; tick();
    chk("clr_dl", o_dl, 0);
    chk("clr_vec", o_vec, 0);

    // broken run
    ax = 2'b01; ticks(10);
    chk("cnt10", o_cnt, 10);
    ax = 2'b00; tick();
    chk("gap_cnt", o_cnt, 0);
    chk("gap_dl", o_dl, 0);
    ax = 2'b01; ticks(15);
    chk("re_pre", o_dl, 0);
    tick();
    chk("re_lock", o_dl, 1);
    clr = 1; tick();

    // clear coincident with 16th cycle
    ticks(15);
    clr = 1; tick();
    chk("cc_dl", o_dl, 0);
    chk("cc_cnt", o_cnt, 0);
    ticks(15);
    chk("cc_pre", o_dl, 0);
    tick();
    chk("cc_lock", o_dl, 1);

`ifdef HLS_DEADLOCK_MON_AUTO_RELEASE_EN
    idle = 12'h000; tick();
    chk("auto_rel", o_dl, 0);
    chk("auto_vec", o_vec, 0);
`endif
    clr = 1; tick();

    // channel-blocked process completes the stop set
    idle = 12'hFF9; blk = 12'h004; ax = 2'b01;
    ticks(16);
    chk("chblk_lock", o_dl, 1);
    clr = 1; blk = '0; tick();

    // both AXIS ports, both owners blocked
    idle = 12'hFF9; ax = 2'b11; ticks(16);
    chk("two_vec", o_vec, 12'h006);
    clr = 1; tick();

    // THRESHOLD=1 instance
    ax1 = 1'b1; idle1 = 3'b111; tick();
    chk("t1_dl", p_dl, 1);
    chk("t1_vec", p_vec, 3'b001);
    chk("t1_cnt", p_cnt, 1);
    rst = 1; tick();
    chk("t1_rst_dl", p_dl, 0);
    chk("t1_rst_blk", p_blk, 0);
    chk("t1_rst_cnt", p_cnt, 0);
    rst = 0; ax1 = 0; idle1 = 0; ax = 0; idle = 0;
    tick();

    // random held segments
    for (int s = 0; s < 40; s++) begin
      ax = 2'($urandom_range(0, 3));
      idle = ($urandom_range(0, 3) != 0) ? 12'hFFF
             : 12'($urandom);
      blk = ($urandom_range(0, 3) == 0) ? 12'($urandom)
            : 12'h000;
      ax1 = 1'($urandom_range(0, 1));
      idle1 = 3'($urandom);
      blk1 = 3'($urandom);
      for (int i = 0; i < int'($urandom_range(1, 22)); i++) begin
        clr = ($urandom_range(0, 30) == 0);
        clr1 = ($urandom_range(0, 5) == 0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
